aes_sub_bytes_seq: RTL and testbench
====================================

Name: aes_sub_bytes_seq

Overview:
- Requester-side controller for the AES S-Box enable/request/acknowledge handshake: drives en, consumes out_req, returns out_ack.
- Streams a masked 128-bit state through SBoxLanes S-Box instances, one byte group per S-Box transaction, and collects the substituted state.
- Presents the full result upstream with the same en/out_req/out_ack handshake.
- Works with both single-cycle (LUT, Canright, Canright masked) and multi-cycle (DOM) S-Box variants without modification.

Parameters:
- SBoxLanes, 1, number of parallel S-Box instances fed per group; legal values 1, 2, 4, 8, 16 (enforced by an init assertion).
- NumGroups, 16/SBoxLanes, derived localparam: S-Box transactions per state.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous and active-low
- en_i  in  1  upstream request; level signal, held high until the result is acknowledged
- out_req_o  out  1  result valid
- out_ack_i  in  1  upstream accepts the result
- op_i  in  ciph_op_e  forward/inverse; sampled at start
- data_i  in  128  masked state; byte k = data_i[8k+7:8k]
- mask_i  in  128  state mask
- data_o  out  128  substituted masked state
- mask_o  out  128  output mask
- sbox_en_o  out  1  enable to all lanes
- sbox_out_req_i  in  SBoxLanes  per-lane result valid
- sbox_out_ack_o  out  1  acknowledge to all lanes
- sbox_op_o  out  ciph_op_e  latched op
- sbox_data_o  out  8*SBoxLanes  current group data; lane j = byte g*SBoxLanes+j
- sbox_mask_o  out  8*SBoxLanes  current group mask
- sbox_data_i  in  8*SBoxLanes  lane results
- sbox_mask_i  in  8*SBoxLanes  lane result masks

Behaviour:
- Reset (rst_ni low at a clock edge): state IDLE, group counter 0, operand/result/op registers 0, out_req_o 0, sbox_en_o 0, sbox_out_ack_o 0, data_o 0, mask_o 0.
- State machine IDLE, ISSUE, DONE:
  - IDLE, en_i=1: latch data_i, mask_i, op_i; counter 0; go to ISSUE. en_i is sampled only in IDLE; operand changes after that are ignored.
  - ISSUE:
    - sbox_en_o=1 continuously.
    - sbox_data_o and sbox_mask_o come from latched group g.
    - sbox_out_ack_o = AND of all sbox_out_req_i bits, combinationally in the same cycle. Lanes that finish early hold their result until the common ack.
    - On ack: write sbox_data_i and sbox_mask_i into result bytes of group g, then g++.
    - On ack with g = NumGroups-1: go to DONE and wrap the counter to 0.
    - New group data appears the cycle after ack.
  - DONE: out_req_o=1 and sbox_en_o=0. On out_ack_i=1, go to IDLE. out_req_o drops the next cycle.
- data_o and mask_o always reflect the result registers. They are guaranteed valid only while out_req_o=1.
- Abort: en_i=0 while in ISSUE or DONE returns to IDLE the next cycle.
  - Counter, operand and result registers are cleared to 0.
  - No out_req_o is issued.
  - sbox_out_ack_o is not asserted in the abort cycle.
- Simultaneous events:
  - In DONE, out_ack_i=1 together with en_i=0 is treated as a normal acknowledge.
  - In IDLE, en_i=1 in the cycle after an acknowledge starts a new operation. Minimum back-to-back gap is 1 IDLE cycle.
- Latency: with per-lane S-Box latency L cycles (L=1 means same-cycle req), en_i is sampled at cycle 0 and out_req_o first rises at cycle 1 + NumGroups*L.
- Masks are passed through unmodified. Unmasked S-Boxes return mask 0, so mask_o = 0.
- No combinational path from en_i to sbox_en_o. out_req_o is a function of state only.

Test Plan:
- SBoxLanes=1, LUT S-Box, forward, data_i = all bytes 0x00, mask 0, en_i held high.
  - Required: out_req_o high at cycle 17, data_o = 0x63 in all 16 bytes.
  - Required: out_ack_i at cycle 17 gives out_req_o low at cycle 18.
- SBoxLanes=4, LUT, inverse, data_i = all bytes 0x63.
  - Required: data_o = 0x00 in every byte.
  - Required: out_req_o at cycle 5.
  - Required: sbox_data_o byte order is 0,1,2,3 then 4..7, etc.
- SBoxLanes=1, stub S-Box with L=5, forward, byte 0 = 0x53, others 0x00.
  - Required: byte 0 = 0xED, others 0x63.
  - Required: out_req_o at cycle 81.
  - Required: exactly 16 sbox_out_ack_o pulses.
- SBoxLanes=2, lane 1 requests 3 cycles after lane 0.
  - Required: sbox_out_ack_o only when both lanes are high.
  - Required: sbox_data_o stable until ack.
- Abort: drop en_i at ISSUE cycle 6.
  - Required: IDLE next cycle and no out_req_o.
  - Required: a new en_i with data 0x01 bytes then yields 0x7C bytes.
- Reset mid-ISSUE (rst_ni low for 1 cycle).
  - Required: all outputs 0 next cycle.
  - Required: out_req_o high in DONE with out_ack_i=0 holds for 10 cycles with stable data_o.

Source files
------------

// File: rtl/aes_sub_bytes_seq_pkg.sv
// Shared types for the SubBytes sequencer: cipher direction encoding.
package aes_sub_bytes_seq_pkg;

  typedef enum logic {
    CIPH_FWD = 1'b0,
    CIPH_INV = 1'b1
  } ciph_op_e;

endpackage

// File: rtl/aes_sub_bytes_seq.sv
// SubBytes sequencer: streams a latched, masked 128-bit state through
// SBoxLanes S-Box instances one byte group at a time using the
// en/out_req/out_ack handshake. The same handshake presents the finished
// state upstream. Each group waits for every lane, so single-cycle and
// multi-cycle S-Box implementations both work unchanged.
module aes_sub_bytes_seq
  import aes_sub_bytes_seq_pkg::*;
#(
  parameter int SBoxLanes = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  output logic                     out_req_o,
  input  logic                     out_ack_i,
  input  ciph_op_e                 op_i,
  input  logic [127:0]             data_i,
  input  logic [127:0]             mask_i,
  output logic [127:0]             data_o,
  output logic [127:0]             mask_o,
  output logic                     sbox_en_o,
  input  logic [SBoxLanes-1:0]     sbox_out_req_i,
  output logic                     sbox_out_ack_o,
  output ciph_op_e                 sbox_op_o,
  output logic [8*SBoxLanes-1:0]   sbox_data_o,
  output logic [8*SBoxLanes-1:0]   sbox_mask_o,
  input  logic [8*SBoxLanes-1:0]   sbox_data_i,
  input  logic [8*SBoxLanes-1:0]   sbox_mask_i
);

  localparam int NumGroups = 16 / SBoxLanes;
  localparam int GroupW    = 8 * SBoxLanes;
  localparam int CntW      = (NumGroups > 1) ? $clog2(NumGroups) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumGroups - 1);

  // Only lane counts that divide the 16-byte state evenly are supported.
  if (!(SBoxLanes == 1 || SBoxLanes == 2 || SBoxLanes == 4 ||
        SBoxLanes == 8 || SBoxLanes == 16)) begin : g_bad_lanes
    $fatal(1, "aes_sub_bytes_seq: SBoxLanes must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // State viewed as NumGroups groups; group g holds bytes g*SBoxLanes+j.
  logic [NumGroups-1:0][GroupW-1:0] r_data_in;
  logic [NumGroups-1:0][GroupW-1:0] r_mask_in;
  logic [NumGroups-1:0][GroupW-1:0] r_data_out;
  logic [NumGroups-1:0][GroupW-1:0] r_mask_out;

  state_e          r_state;
  state_e          w_state_next;
  logic [CntW-1:0] r_cnt;
  ciph_op_e        r_op;
  logic            r_out_req;
  logic            r_sbox_en;

  logic w_all_req;
  logic w_start;
  logic w_grp_ack;
  logic w_abort;

  assign w_all_req = &sbox_out_req_i;

  // Next-state decode and the single-cycle strobes derived from it.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_grp_ack    = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en_i) begin
          w_state_next = S_ISSUE;
          w_start      = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (!en_i) begin
          // Requester withdrew: drop everything, never ack the lanes.
          w_state_next = S_IDLE;
          w_abort      = 1'b1;
        end else if (w_all_req) begin
          w_grp_ack = 1'b1;
          if (r_cnt == LastCnt) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_ISSUE;
          end
        end else begin
          w_state_next = S_ISSUE;
        end
      end
      S_DONE: begin
        // An acknowledge wins over a simultaneous withdrawal.
        if (out_ack_i) begin
          w_state_next = S_IDLE;
        end else if (!en_i) begin
          w_state_next = S_IDLE;
          w_abort      = 1'b1;
        end else begin
          w_state_next = S_DONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_abort      = 1'b1;
      end
    endcase
  end

  // State, handshake flags, group counter and operand/result storage.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_out_req  <= 1'b0;
      r_sbox_en  <= 1'b0;
      r_cnt      <= '0;
      r_op       <= CIPH_FWD;
      r_data_in  <= '0;
      r_mask_in  <= '0;
      r_data_out <= '0;
      r_mask_out <= '0;
    end else begin
      r_state   <= w_state_next;
      r_out_req <= (w_state_next == S_DONE);
      r_sbox_en <= (w_state_next == S_ISSUE);
      if (w_abort) begin
        r_cnt      <= '0;
        r_op       <= CIPH_FWD;
        r_data_in  <= '0;
        r_mask_in  <= '0;
        r_data_out <= '0;
        r_mask_out <= '0;
      end else if (w_start) begin
        r_cnt     <= '0;
        r_op      <= op_i;
        r_data_in <= data_i;
        r_mask_in <= mask_i;
      end else if (w_grp_ack) begin
        r_data_out[r_cnt] <= sbox_data_i;
        r_mask_out[r_cnt] <= sbox_mask_i;
        if (r_cnt == LastCnt) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CntW'(1);
        end
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  assign out_req_o      = r_out_req;
  assign sbox_en_o      = r_sbox_en;
  assign sbox_out_ack_o = w_grp_ack;
  assign sbox_op_o      = r_op;
  assign sbox_data_o    = r_data_in[r_cnt];
  assign sbox_mask_o    = r_mask_in[r_cnt];
  assign data_o         = r_data_out;
  assign mask_o         = r_mask_out;

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Directed bench for aes_sub_bytes_seq: three instances (1, 4 and 2 lanes)
// driven by small behavioural S-Box responders with programmable latency.
module tb_aes_sub_bytes_seq;
  import aes_sub_bytes_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Partial AES S-Box: only entries used by the directed vectors.
  function automatic logic [7:0] sbox_f(input ciph_op_e op, input logic [7:0] x);
    logic [7:0] y;
    if (op == CIPH_FWD) begin
      case (x)
        8'h00:   y = 8'h63;
        8'h01:   y = 8'h7C;
        8'h53:   y = 8'hED;
        default: y = ~x;
      endcase
    end else begin
      case (x)
        8'h63:   y = 8'h00;
        8'h7C:   y = 8'h01;
        8'hED:   y = 8'h53;
        default: y = ~x;
      endcase
    end
    return y;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- instance A: 1 lane, programmable latency ----------------
  logic a_en, a_out_req, a_out_ack, a_sbox_en, a_sbox_ack;
  logic [0:0] a_sbox_req;
  ciph_op_e a_op, a_sbox_op;
  logic [127:0] a_data, a_mask, a_data_o, a_mask_o;
  logic [7:0] a_sbox_data_o, a_sbox_mask_o, a_sbox_data_i, a_sbox_mask_i;
  logic [7:0] a_cnt = 8'd0;
  int a_lat = 1;
  int a_acks = 0;

  aes_sub_bytes_seq #(.SBoxLanes(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(a_en), .out_req_o(a_out_req),
    .out_ack_i(a_out_ack), .op_i(a_op), .data_i(a_data), .mask_i(a_mask),
    .data_o(a_data_o), .mask_o(a_mask_o), .sbox_en_o(a_sbox_en),
    .sbox_out_req_i(a_sbox_req), .sbox_out_ack_o(a_sbox_ack), .sbox_op_o(a_sbox_op),
    .sbox_data_o(a_sbox_data_o), .sbox_mask_o(a_sbox_mask_o),
    .sbox_data_i(a_sbox_data_i), .sbox_mask_i(a_sbox_mask_i)
  );

  // Lane A cycle counter since group start, plus total ack pulses.
  always @(posedge clk) begin
    if (!a_sbox_en || a_sbox_ack) a_cnt <= 8'd0;
    else if (a_cnt != 8'hFF)      a_cnt <= a_cnt + 8'd1;
    if (a_sbox_ack === 1'b1)      a_acks <= a_acks + 1;
  end

  assign a_sbox_req[0] = a_sbox_en && (int'(a_cnt) >= a_lat - 1);
  assign a_sbox_data_i = sbox_f(a_sbox_op, a_sbox_data_o);
  assign a_sbox_mask_i = 8'h00;

  // ---------------- instance B: 4 lanes, latency 1 ----------------
  logic b_en, b_out_req, b_out_ack, b_sbox_en, b_sbox_ack;
  logic [3:0] b_sbox_req;
  ciph_op_e b_op, b_sbox_op;
  logic [127:0] b_data, b_mask, b_data_o, b_mask_o;
  logic [31:0] b_sbox_data_o, b_sbox_mask_o, b_sbox_data_i, b_sbox_mask_i;

  aes_sub_bytes_seq #(.SBoxLanes(4)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(b_en), .out_req_o(b_out_req),
    .out_ack_i(b_out_ack), .op_i(b_op), .data_i(b_data), .mask_i(b_mask),
    .data_o(b_data_o), .mask_o(b_mask_o), .sbox_en_o(b_sbox_en),
    .sbox_out_req_i(b_sbox_req), .sbox_out_ack_o(b_sbox_ack), .sbox_op_o(b_sbox_op),
    .sbox_data_o(b_sbox_data_o), .sbox_mask_o(b_sbox_mask_o),
    .sbox_data_i(b_sbox_data_i), .sbox_mask_i(b_sbox_mask_i)
  );

  assign b_sbox_req = {4{b_sbox_en}};
  for (genvar j = 0; j < 4; j++) begin : g_b_lane
    assign b_sbox_data_i[8*j +: 8] = sbox_f(b_sbox_op, b_sbox_data_o[8*j +: 8]);
    assign b_sbox_mask_i[8*j +: 8] = b_sbox_mask_o[8*j +: 8] + 8'h10;
  end

  // ---------------- instance C: 2 lanes, lane 1 three cycles late ----------------
  logic c_en, c_out_req, c_out_ack, c_sbox_en, c_sbox_ack;
  logic [1:0] c_sbox_req;
  ciph_op_e c_op, c_sbox_op;
  logic [127:0] c_data, c_mask, c_data_o, c_mask_o;
  logic [15:0] c_sbox_data_o, c_sbox_mask_o, c_sbox_data_i, c_sbox_mask_i;
  logic [7:0] c_cnt = 8'd0;

  aes_sub_bytes_seq #(.SBoxLanes(2)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .en_i(c_en), .out_req_o(c_out_req),
    .out_ack_i(c_out_ack), .op_i(c_op), .data_i(c_data), .mask_i(c_mask),
    .data_o(c_data_o), .mask_o(c_mask_o), .sbox_en_o(c_sbox_en),
    .sbox_out_req_i(c_sbox_req), .sbox_out_ack_o(c_sbox_ack), .sbox_op_o(c_sbox_op),
    .sbox_data_o(c_sbox_data_o), .sbox_mask_o(c_sbox_mask_o),
    .sbox_data_i(c_sbox_data_i), .sbox_mask_i(c_sbox_mask_i)
  );

  // Instance C cycle counter since group start.
  always @(posedge clk) begin
    if (!c_sbox_en || c_sbox_ack) c_cnt <= 8'd0;
    else if (c_cnt != 8'hFF)      c_cnt <= c_cnt + 8'd1;
  end

  assign c_sbox_req[0] = c_sbox_en;
  assign c_sbox_req[1] = c_sbox_en && (c_cnt >= 8'd3);
  for (genvar j = 0; j < 2; j++) begin : g_c_lane
    assign c_sbox_data_i[8*j +: 8] = sbox_f(c_sbox_op, c_sbox_data_o[8*j +: 8]);
    assign c_sbox_mask_i[8*j +: 8] = 8'h00;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int   snap;
    logic seen;
    rst_n = 1'b0;
    a_en = 1'b0; a_out_ack = 1'b0; a_op = CIPH_FWD; a_data = '0; a_mask = '0;
    b_en = 1'b0; b_out_ack = 1'b0; b_op = CIPH_FWD; b_data = '0; b_mask = '0;
    c_en = 1'b0; c_out_ack = 1'b0; c_op = CIPH_FWD; c_data = '0; c_mask = '0;
    tick(2);

    // Reset state
    chk("rst_out_req",  a_out_req, 128'd0);
    chk("rst_sbox_en",  a_sbox_en, 128'd0);
    chk("rst_sbox_ack", a_sbox_ack, 128'd0);
    chk("rst_data_o",   a_data_o, 128'd0);
    chk("rst_mask_o",   a_mask_o, 128'd0);
    chk("rst_b_out_req", b_out_req, 128'd0);
    chk("rst_c_out_req", c_out_req, 128'd0);
    rst_n = 1'b1;
    tick(1);

    // T1: 1 lane, forward, all zero -> all 0x63 at cycle 17
    a_data = '0; a_mask = '0; a_op = CIPH_FWD; a_lat = 1; a_en = 1'b1;
    snap = a_acks;
    tick(1);
    chk("t1_sbox_en_c1", a_sbox_en, 128'd1);
    tick(15);
    chk("t1_out_req_c16", a_out_req, 128'd0);
    tick(1);
    chk("t1_out_req_c17", a_out_req, 128'd1);
    chk("t1_data_o", a_data_o, {16{8'h63}});
    chk("t1_mask_o", a_mask_o, 128'd0);
    chk("t1_acks", 128'(a_acks - snap), 128'd16);
    chk("t1_sbox_en_done", a_sbox_en, 128'd0);
    a_out_ack = 1'b1;
    tick(1);
    chk("t1_out_req_c18", a_out_req, 128'd0);
    a_out_ack = 1'b0; a_en = 1'b0;
    tick(1);

    // T2: 4 lanes, inverse, all 0x63 -> 0x00 at cycle 5, group order check
    b_data = {16{8'h63}}; b_mask = 128'h0f0e0d0c0b0a09080706050403020100;
    b_op = CIPH_INV; b_en = 1'b1;
    for (int g = 0; g < 4; g++) begin
      tick(1);
      chk("t2_grp_mask", b_sbox_mask_o, {8'(4*g+3), 8'(4*g+2), 8'(4*g+1), 8'(4*g)});
      chk("t2_grp_data", b_sbox_data_o, 32'h63636363);
      chk("t2_out_req_early", b_out_req, 128'd0);
    end
    tick(1);
    chk("t2_out_req_c5", b_out_req, 128'd1);
    chk("t2_data_o", b_data_o, 128'd0);
    chk("t2_mask_o", b_mask_o, 128'h1f1e1d1c1b1a19181716151413121110);
    b_out_ack = 1'b1;
    tick(1);
    b_out_ack = 1'b0; b_en = 1'b0;
    tick(1);

    // T3: 1 lane, latency 5, byte0 0x53 -> 0xED, others 0x63, cycle 81
    a_data = 128'h53; a_lat = 5; a_en = 1'b1;
    snap = a_acks;
    tick(80);
    chk("t3_out_req_c80", a_out_req, 128'd0);
    tick(1);
    chk("t3_out_req_c81", a_out_req, 128'd1);
    chk("t3_data_o", a_data_o, {{15{8'h63}}, 8'hED});
    chk("t3_acks", 128'(a_acks - snap), 128'd16);
    // ack together with en low counts as a normal acknowledge
    a_out_ack = 1'b1; a_en = 1'b0;
    tick(1);
    chk("t3_out_req_after_ack", a_out_req, 128'd0);
    chk("t3_data_kept", a_data_o, {{15{8'h63}}, 8'hED});
    a_out_ack = 1'b0; a_lat = 1;
    tick(1);

    // T4: 2 lanes, lane 1 late
    c_data = {8{16'h0100}}; c_mask = 128'h0f0e0d0c0b0a09080706050403020100;
    c_op = CIPH_FWD; c_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      chk("t4_no_ack_partial", c_sbox_ack, 128'd0);
      chk("t4_mask_stable", c_sbox_mask_o, 16'h0100);
      chk("t4_data_stable", c_sbox_data_o, 16'h0100);
    end
    tick(1);
    chk("t4_ack_both", c_sbox_ack, 128'd1);
    chk("t4_mask_at_ack", c_sbox_mask_o, 16'h0100);
    tick(1);
    chk("t4_next_group", c_sbox_mask_o, 16'h0302);
    chk("t4_no_ack_next", c_sbox_ack, 128'd0);
    tick(27);
    chk("t4_out_req_c32", c_out_req, 128'd0);
    tick(1);
    chk("t4_out_req_c33", c_out_req, 128'd1);
    chk("t4_data_o", c_data_o, {8{16'h7C63}});
    chk("t4_mask_o", c_mask_o, 128'd0);
    c_out_ack = 1'b1;
    tick(1);
    c_out_ack = 1'b0; c_en = 1'b0;
    tick(1);

    // T5: abort at ISSUE cycle 6, then a fresh operation
    a_data = {16{8'h53}}; a_lat = 1; a_en = 1'b1;
    snap = a_acks;
    tick(6);
    a_en = 1'b0;
    #1;
    chk("t5_no_ack_abort", a_sbox_ack, 128'd0);
    tick(1);
    chk("t5_idle_sbox_en", a_sbox_en, 128'd0);
    chk("t5_idle_out_req", a_out_req, 128'd0);
    chk("t5_cleared_data_o", a_data_o, 128'd0);
    chk("t5_cleared_operand", a_sbox_data_o, 128'd0);
    chk("t5_acks", 128'(a_acks - snap), 128'd5);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      seen = seen | a_out_req;
    end
    chk("t5_no_out_req", seen, 128'd0);
    a_data = {16{8'h01}}; a_en = 1'b1;
    tick(17);
    chk("t5_restart_out_req", a_out_req, 128'd1);
    chk("t5_restart_data", a_data_o, {16{8'h7C}});
    a_out_ack = 1'b1;
    tick(1);
    a_out_ack = 1'b0; a_en = 1'b0;
    tick(1);

    // T6: reset mid-ISSUE, then held result in DONE
    a_data = {16{8'h01}}; a_lat = 5; a_en = 1'b1;
    tick(7);
    rst_n = 1'b0;
    tick(1);
    chk("t6_rst_out_req", a_out_req, 128'd0);
    chk("t6_rst_sbox_en", a_sbox_en, 128'd0);
    chk("t6_rst_sbox_ack", a_sbox_ack, 128'd0);
    chk("t6_rst_data_o", a_data_o, 128'd0);
    chk("t6_rst_mask_o", a_mask_o, 128'd0);
    chk("t6_rst_sbox_data", a_sbox_data_o, 128'd0);
    rst_n = 1'b1; a_lat = 1;
    tick(17);
    chk("t6_out_req", a_out_req, 128'd1);
    chk("t6_data_o", a_data_o, {16{8'h7C}});
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("t6_hold_out_req", a_out_req, 128'd1);
      chk("t6_hold_data", a_data_o, {16{8'h7C}});
    end
    a_out_ack = 1'b1;
    tick(1);
    chk("t6_out_req_drop", a_out_req, 128'd0);
    a_out_ack = 1'b0; a_en = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
